sha256_msg_padder: RTL and testbench



---
 rtl/sha256_pkg.sv | 32 +++
 rtl/sha256_msg_padder_if.sv | 29 ++
 rtl/sha256_pad_block_buf.sv | 69 ++++++
 rtl/sha256_msg_padder.sv | 193 +++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared types and constants for the SHA-256 message padder.
//   state_e : padder FSM states (IDLE, FILL, SEND, EXTRA)
//   kind_e  : how the block currently being emitted is synthesised on read
//   BLOCK_BYTES, LEN_OFFSET, PAD_BYTE : block geometry and the terminator byte
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SEND,
        EXTRA
    } state_e;

    // DATA     : buffered bytes, zeros beyond n
    // FINAL    : bytes, 0x80 terminator, zero fill, 64-bit length
    // PAD_ONLY : bytes, 0x80 terminator, zeros (length goes in the next block)
    // LEN_ONLY : zeros and the 64-bit length
    // FULL_PAD : 0x80, zeros and the 64-bit length
    typedef enum logic [2:0] {
        DATA,
        FINAL,
        PAD_ONLY,
        LEN_ONLY,
        FULL_PAD
    } kind_e;

    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if
// Byte-stream input and block-word output handshakes of the padder.
//   in_data/in_valid/in_last/in_empty -> in_ready : byte source side
//   out_data/out_valid/out_block_last/out_msg_last <- out_ready : SHA core side
// Modports: slave (the padder), master (the byte source / core model).
interface sha256_msg_padder_if #(
    parameter int OUT_WIDTH = 32
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_empty;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_block_last;
    logic                 out_msg_last;

    modport slave (
        input  in_data, in_valid, in_last, in_empty, out_ready,
        output in_ready, out_data, out_valid, out_block_last, out_msg_last
    );

    modport master (
        output in_data, in_valid, in_last, in_empty, out_ready,
        input  in_ready, out_data, out_valid, out_block_last, out_msg_last
    );
endinterface

// File: rtl/sha256_pad_block_buf.sv
// sha256_pad_block_buf
// 64x8 block storage with one byte write port and a combinational padded
// word read. Padding bytes are never stored; they are synthesised from the
// block kind, the data byte count n and the message bit length.
//   clk                          : write clock
//   wr_en_i/wr_addr_i/wr_data_i  : byte write port
//   kind_i, n_i, bit_len_i       : how to synthesise the block
//   word_i                       : word index within the block
//   word_o                       : big-endian OUT_WIDTH-bit word
module sha256_pad_block_buf
    import sha256_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    localparam int WPB  = 512 / OUT_WIDTH,
    localparam int WIDX = $clog2(WPB)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [5:0]           wr_addr_i,
    input  logic [7:0]           wr_data_i,
    input  kind_e                kind_i,
    input  logic [6:0]           n_i,
    input  logic [63:0]          bit_len_i,
    input  logic [WIDX-1:0]      word_i,
    output logic [OUT_WIDTH-1:0] word_o
);

    localparam int BPW = OUT_WIDTH / 8;

    logic [7:0] mem_q [BLOCK_BYTES];

    // Byte storage; contents are only meaningful below the fill index, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Build each byte of the requested word from the padding rules. A byte
    // being written this same cycle is forwarded so the word can be
    // registered in the cycle that completes the block.
    always_comb begin
        int         k;
        logic [5:0] kIdx;
        logic [7:0] b;
        word_o = '0;
        k      = 0;
        kIdx   = '0;
        b      = '0;
        for (int j = 0; j < BPW; j++) begin
            k    = int'(word_i) * BPW + j;
            kIdx = 6'(k);
            if (k < int'(n_i)) begin
                b = (wr_en_i && wr_addr_i == kIdx) ? wr_data_i : mem_q[kIdx];
            end else if ((k == int'(n_i) && (kind_i == FINAL || kind_i == PAD_ONLY)) ||
                         (k == 0 && kind_i == FULL_PAD)) begin
                b = PAD_BYTE;
            end else if (k >= LEN_OFFSET &&
                         (kind_i == FINAL || kind_i == LEN_ONLY || kind_i == FULL_PAD)) begin
                b = bit_len_i[8*(63-k) +: 8];
            end else begin
                b = 8'h00;
            end
            word_o[OUT_WIDTH-1-8*j -: 8] = b;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Accepts a byte stream and emits FIPS 180-4 padded 512-bit blocks as
// OUT_WIDTH-bit big-endian words (OUT_WIDTH = 8, 32 or 64).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sha256_msg_padder_if.slave (byte input, word output)
//   raw_mode   : only with SHA_PAD_RAW_MODE_EN defined; sampled on the first
//                beat of a message, passes blocks through without padding
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int OUT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef SHA_PAD_RAW_MODE_EN
    input  logic                raw_mode,
`endif
    sha256_msg_padder_if.slave  bus
);

    localparam int              WPB   = 512 / OUT_WIDTH;
    localparam int              WIDX  = $clog2(WPB);
    localparam logic [WIDX-1:0] WLAST = WIDX'(WPB - 1);

    state_e               state_q, state_d;
    kind_e                kind_q, kind_d;
    logic [6:0]           fill_q, fill_d;
    logic [60:0]          len_q, len_d;
    logic [WIDX-1:0]      word_q, word_d;
    logic                 extra_q, extra_d;
    logic                 final_q, final_d;
    logic                 in_ready_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic                 out_valid_q, block_last_q, msg_last_q;

    logic                 accept, hasByte, fire, rawSel, valid_d;
    logic [6:0]           nNew, readN;
    logic [OUT_WIDTH-1:0] rdWord;

    assign accept  = bus.in_valid & in_ready_q;
    assign hasByte = accept & ~bus.in_empty;
    assign fire    = out_valid_q & bus.out_ready;

`ifdef SHA_PAD_RAW_MODE_EN
    logic raw_q;

    // Remember the raw-mode choice made on the first beat of the message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
        end else if (accept && state_q == IDLE) begin
            raw_q <= raw_mode;
        end
    end

    assign rawSel = (state_q == IDLE) ? raw_mode : raw_q;
`else
    assign rawSel = 1'b0;
`endif

    // Next-state logic: fill the buffer, classify the end of message into
    // the block kinds, then walk the word index while draining.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        fill_d  = fill_q;
        len_d   = len_q;
        word_d  = word_q;
        extra_d = extra_q;
        final_d = final_q;
        nNew    = fill_q + {6'd0, hasByte};
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    if (hasByte) begin
                        fill_d = nNew;
                        len_d  = len_q + 61'd1;
                    end
                    state_d = FILL;
                    if (bus.in_last) begin
                        state_d = SEND;
                        word_d  = '0;
                        if (rawSel) begin
                            kind_d  = DATA;
                            final_d = 1'b1;
                            extra_d = 1'b0;
                        end else if (nNew <= 7'(LEN_OFFSET - 1)) begin
                            kind_d  = FINAL;
                            final_d = 1'b1;
                            extra_d = 1'b0;
                        end else if (nNew < 7'(BLOCK_BYTES)) begin
                            kind_d  = PAD_ONLY;
                            final_d = 1'b0;
                            extra_d = 1'b1;
                        end else begin
                            kind_d  = DATA;
                            final_d = 1'b0;
                            extra_d = 1'b1;
                        end
                    end else if (nNew == 7'(BLOCK_BYTES)) begin
                        state_d = SEND;
                        word_d  = '0;
                        kind_d  = DATA;
                        final_d = 1'b0;
                        extra_d = 1'b0;
                    end
                end
            end
            SEND, EXTRA: begin
                if (fire) begin
                    if (word_q == WLAST) begin
                        if (extra_q) begin
                            state_d = EXTRA;
                            kind_d  = (kind_q == PAD_ONLY) ? LEN_ONLY : FULL_PAD;
                            final_d = 1'b1;
                            extra_d = 1'b0;
                            word_d  = '0;
                        end else if (final_q) begin
                            state_d = IDLE;
                            fill_d  = '0;
                            len_d   = '0;
                            final_d = 1'b0;
                        end else begin
                            state_d = FILL;
                            fill_d  = '0;
                        end
                    end else begin
                        word_d = word_q + WIDX'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Extra blocks hold no message bytes, so their data count reads as zero.
    assign valid_d = (state_d == SEND) || (state_d == EXTRA);
    assign readN   = (state_d == EXTRA) ? 7'd0 : fill_d;

    sha256_pad_block_buf #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (hasByte),
        .wr_addr_i (fill_q[5:0]),
        .wr_data_i (bus.in_data),
        .kind_i    (kind_d),
        .n_i       (readN),
        .bit_len_i ({len_d, 3'b000}),
        .word_i    (word_d),
        .word_o    (rdWord)
    );

    // State and output registers. The output word is computed from the
    // next-state view so it is already valid the cycle after the completing
    // beat, and it is recomputed identically while the core stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            kind_q       <= DATA;
            fill_q       <= '0;
            len_q        <= '0;
            word_q       <= '0;
            extra_q      <= 1'b0;
            final_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            block_last_q <= 1'b0;
            msg_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            fill_q       <= fill_d;
            len_q        <= len_d;
            word_q       <= word_d;
            extra_q      <= extra_d;
            final_q      <= final_d;
            in_ready_q   <= (state_d == IDLE) || (state_d == FILL);
            out_data_q   <= valid_d ? rdWord : '0;
            out_valid_q  <= valid_d;
            block_last_q <= valid_d && (word_d == WLAST);
            msg_last_q   <= valid_d && (word_d == WLAST) && final_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_block_last = block_last_q;
    assign bus.out_msg_last   = msg_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder
// Self-checking bench for sha256_msg_padder (OUT_WIDTH = 32): a table of
// known messages, randomized messages against a byte-level padding model,
// and a reset-abort sequence.
module tb_sha256_msg_padder;

    localparam int OUT_WIDTH = 32;
    localparam int WPB       = 512 / OUT_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    sha256_msg_padder_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

`ifdef SHA_PAD_RAW_MODE_EN
    logic rawMode = 1'b0;
`endif

    sha256_msg_padder #(
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SHA_PAD_RAW_MODE_EN
        .raw_mode (rawMode),
`endif
        .bus      (bus)
    );

    typedef struct {
        int          len;
        int          pattern;
        bit          emptyTail;
        int          readyMode;
        int          wordIdx;
        logic [31:0] expWord;
        int          expWords;
    } vecT;

    vecT         vecs[12];
    int          vecCount  = 0;
    int          missCount = 0;
    logic [7:0]  msg[$];
    bit          emptyTail;
    logic [31:0] capWords[$];

    // One comparison: counts it and reports a miscompare.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Build msg from a pattern: 0 = 'a','b','c'..., 1 = 0x41, 2 = random.
    task automatic buildMsg(input int len, input int pattern);
        msg.delete();
        for (int i = 0; i < len; i++) begin
            case (pattern)
                0:       msg.push_back(8'(8'h61 + i));
                1:       msg.push_back(8'h41);
                default: msg.push_back(8'($urandom));
            endcase
        end
    endtask

    // Drive msg as beats and drain the output, checking every presented
    // word and flag against the padding model. readyMode: 0 always ready,
    // 1 toggling, 2 random. abortAt >= 0 stops once that many words drained.
    task automatic applyStimulus(input int readyMode, input int abortAt, output bit aborted);
        logic [7:0]  pad[$];
        logic [31:0] expWords[$];
        logic [63:0] bitLen;
        int          numBeats, completeBeat, beatIdx, outIdx, cycle;
        int          acceptCycle, firstValid;
        bit          readyLeak, extraValid;

        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bitLen = 64'(msg.size()) * 64'd8;
        for (int b = 7; b >= 0; b--) pad.push_back(bitLen[8*b +: 8]);
        expWords.delete();
        for (int i = 0; i < pad.size() / 4; i++) begin
            expWords.push_back({pad[4*i], pad[4*i+1], pad[4*i+2], pad[4*i+3]});
        end

        numBeats     = msg.size() + ((emptyTail || msg.size() == 0) ? 1 : 0);
        completeBeat = (msg.size() >= 64) ? 63 : numBeats - 1;
        beatIdx      = 0;
        outIdx       = 0;
        cycle        = 0;
        acceptCycle  = -100;
        firstValid   = -1;
        readyLeak    = 1'b0;
        aborted      = 1'b0;
        capWords.delete();

        while (outIdx < expWords.size() && cycle < 4000) begin
            @(negedge clk);
            cycle++;
            if (abortAt >= 0 && outIdx >= abortAt) begin
                aborted = 1'b1;
                break;
            end
            if (beatIdx < numBeats) begin
                bus.in_valid = 1'b1;
                bus.in_empty = (beatIdx >= msg.size());
                bus.in_data  = (beatIdx < msg.size()) ? msg[beatIdx] : 8'($urandom);
                bus.in_last  = (beatIdx == numBeats - 1);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom);
            end
            case (readyMode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = cycle[0];
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (bus.in_valid && bus.in_ready) begin
                if (beatIdx == completeBeat) acceptCycle = cycle;
                beatIdx++;
            end
            if (bus.out_valid) begin
                if (firstValid < 0) firstValid = cycle;
                if (bus.in_ready) readyLeak = 1'b1;
                checkOutput($sformatf("word%0d", outIdx), bus.out_data, expWords[outIdx]);
                checkOutput($sformatf("blockLast%0d", outIdx), bus.out_block_last,
                            (outIdx % WPB) == WPB - 1);
                checkOutput($sformatf("msgLast%0d", outIdx), bus.out_msg_last,
                            outIdx == expWords.size() - 1);
                if (bus.out_ready) begin
                    capWords.push_back(bus.out_data);
                    outIdx++;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        checkOutput("latency", 64'(firstValid - acceptCycle), 64'd1);
        checkOutput("inReadyDuringSend", readyLeak, 1'b0);
        if (!aborted) begin
            checkOutput("wordsReceived", outIdx, expWords.size());
            extraValid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (bus.out_valid) extraValid = 1'b1;
            end
            checkOutput("noExtraWords", extraValid, 1'b0);
        end
    endtask

    initial begin
        bit aborted;

        vecs[0]  = '{3,   0, 1'b0, 0, 0,  32'h61626380, 16};
        vecs[1]  = '{3,   0, 1'b1, 2, 15, 32'h00000018, 16};
        vecs[2]  = '{55,  1, 1'b0, 0, 13, 32'h41414180, 16};
        vecs[3]  = '{55,  1, 1'b0, 2, 15, 32'h000001B8, 16};
        vecs[4]  = '{56,  1, 1'b0, 0, 14, 32'h80000000, 32};
        vecs[5]  = '{56,  1, 1'b1, 0, 15, 32'h00000000, 32};
        vecs[6]  = '{56,  1, 1'b0, 1, 31, 32'h000001C0, 32};
        vecs[7]  = '{64,  2, 1'b0, 0, 16, 32'h80000000, 32};
        vecs[8]  = '{64,  2, 1'b1, 0, 31, 32'h00000200, 32};
        vecs[9]  = '{0,   0, 1'b0, 0, 0,  32'h80000000, 16};
        vecs[10] = '{0,   0, 1'b0, 1, 15, 32'h00000000, 16};
        vecs[11] = '{130, 2, 1'b0, 1, 47, 32'h00000410, 48};

        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b0;
        bus.in_empty  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("resetInReady", bus.in_ready, 1'b0);
        checkOutput("resetOutValid", bus.out_valid, 1'b0);
        checkOutput("resetOutData", bus.out_data, '0);
        checkOutput("resetBlockLast", bus.out_block_last, 1'b0);
        checkOutput("resetMsgLast", bus.out_msg_last, 1'b0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterReset", bus.in_ready, 1'b1);

        // Known-answer table.
        for (int v = 0; v < 12; v++) begin
            buildMsg(vecs[v].len, vecs[v].pattern);
            emptyTail = vecs[v].emptyTail;
            applyStimulus(vecs[v].readyMode, -1, aborted);
            checkOutput($sformatf("vec%0dCount", v), capWords.size(), vecs[v].expWords);
            if (capWords.size() > vecs[v].wordIdx) begin
                checkOutput($sformatf("vec%0dWord%0d", v, vecs[v].wordIdx),
                            capWords[vecs[v].wordIdx], vecs[v].expWord);
            end else begin
                checkOutput($sformatf("vec%0dWord%0dMissing", v, vecs[v].wordIdx),
                            64'd0, 64'd1);
            end
        end

        // Randomized messages against the model.
        for (int r = 0; r < 20; r++) begin
            buildMsg($urandom_range(0, 200), 2);
            emptyTail = 1'($urandom);
            applyStimulus(2, -1, aborted);
        end

        // Reset pulsed mid-way through block 1 of a 130-byte message.
        buildMsg(130, 2);
        emptyTail = 1'b0;
        applyStimulus(1, 20, aborted);
        checkOutput("abortReached", aborted, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abortOutValid", bus.out_valid, 1'b0);
        checkOutput("abortOutData", bus.out_data, '0);
        checkOutput("abortMsgLast", bus.out_msg_last, 1'b0);
        checkOutput("abortInReady", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) aborted = 1'b1;
        end
        checkOutput("noPartialAfterAbort", aborted, 1'b0);

        // Clean message after the abort.
        buildMsg(3, 0);
        emptyTail = 1'b0;
        applyStimulus(0, -1, aborted);
        checkOutput("postAbortWord0", capWords.size() > 0 ? capWords[0] : 32'hDEAD_BEEF,
                    32'h61626380);
        checkOutput("postAbortWord15", capWords.size() > 15 ? capWords[15] : 32'hDEAD_BEEF,
                    32'h00000018);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
